// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: synchronises the pushbuttons, edge-detects wall hits and runs the
// menu / set / serve / play / point / game-over flow in a single clock domain.
module pong_game_ctrl #(
    parameter int unsigned MAX_SCORE_INIT    = 5,
    parameter int unsigned MAX_SCORE_LIMIT   = 20,
    parameter int unsigned POINT_HOLD_FRAMES = 60
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_frame_tick,
    input  logic       i_btn_launch,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    input  logic       i_left_hit,
    input  logic       i_right_hit,
    output logic [2:0] o_state,
    output logic [4:0] o_max_score,
    output logic [4:0] o_score_p1,
    output logic [4:0] o_score_p2,
    output logic       o_serve_player,
    output logic       o_winner,
    output logic       o_serve_load
);

    localparam int unsigned HOLD_W = $clog2(POINT_HOLD_FRAMES + 1);

    typedef enum logic [2:0] {
        StMenu     = 3'd0,
        StSet      = 3'd1,
        StStart    = 3'd2,
        StPlay     = 3'd3,
        StEndPoint = 3'd4,
        StEndGame  = 3'd5
    } state_e;

    state_e            r_state;
    logic [2:0]        r_sync1;
    logic [2:0]        r_sync2;
    logic [2:0]        r_btn_d;
    logic [1:0]        r_warm;
    logic              r_lh_d;
    logic              r_rh_d;
    logic [4:0]        r_max;
    logic [4:0]        r_p1;
    logic [4:0]        r_p2;
    logic              r_serve;
    logic              r_winner;
    logic              r_serve_load;
    logic              r_win;
    logic [HOLD_W-1:0] r_hold;

    logic [2:0] w_btn_p;
    logic       w_launch_p;
    logic       w_up_p;
    logic       w_down_p;
    logic       w_lh_p;
    logic       w_rh_p;
    logic [4:0] w_p1_inc;
    logic [4:0] w_p2_inc;

    // Edges are only trusted once the synchroniser holds two real post-reset samples, so a
    // button held through reset release never produces a pulse.
    assign w_btn_p    = r_sync2 & ~r_btn_d & {3{r_warm == 2'd3}};
    assign w_launch_p = w_btn_p[0];
    assign w_up_p     = w_btn_p[1];
    assign w_down_p   = w_btn_p[2];
    assign w_lh_p     = i_left_hit & ~r_lh_d;
    assign w_rh_p     = i_right_hit & ~r_rh_d;
    assign w_p1_inc   = r_p1 + 5'd1;
    assign w_p2_inc   = r_p2 + 5'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
            r_btn_d <= 3'b000;
            r_warm  <= 2'd0;
            r_lh_d  <= 1'b0;
            r_rh_d  <= 1'b0;
        end else begin
            r_sync1 <= {i_btn_down, i_btn_up, i_btn_launch};
            r_sync2 <= r_sync1;
            r_btn_d <= r_sync2;
            if (r_warm != 2'd3) begin
                r_warm <= r_warm + 2'd1;
            end
            r_lh_d <= i_left_hit;
            r_rh_d <= i_right_hit;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StMenu;
            r_max        <= 5'(MAX_SCORE_INIT);
            r_p1         <= 5'd0;
            r_p2         <= 5'd0;
            r_serve      <= 1'b0;
            r_winner     <= 1'b0;
            r_serve_load <= 1'b0;
            r_win        <= 1'b0;
            r_hold       <= '0;
        end else begin
            r_serve_load <= 1'b0;
            case (r_state)
                StMenu: begin
                    if (w_launch_p) begin
                        r_state <= StSet;
                    end
                end
                StSet: begin
                    if (w_launch_p) begin
                        r_state      <= StStart;
                        r_p1         <= 5'd0;
                        r_p2         <= 5'd0;
                        r_serve      <= 1'b0;
                        r_serve_load <= 1'b1;
                    end else if (w_up_p && !w_down_p) begin
                        if (r_max < 5'(MAX_SCORE_LIMIT)) begin
                            r_max <= r_max + 5'd1;
                        end
                    end else if (w_down_p && !w_up_p) begin
                        if (r_max > 5'd1) begin
                            r_max <= r_max - 5'd1;
                        end
                    end
                end
                StStart: begin
                    if (w_launch_p) begin
                        r_state <= StPlay;
                    end
                end
                StPlay: begin
                    // A hit on the right wall scores for the left player and vice versa.
                    if (w_rh_p && !w_lh_p) begin
                        r_p1    <= w_p1_inc;
                        r_serve <= 1'b1;
                        r_win   <= (w_p1_inc == r_max);
                        if (w_p1_inc == r_max) begin
                            r_winner <= 1'b0;
                        end
                        r_hold  <= '0;
                        r_state <= StEndPoint;
                    end else if (w_lh_p && !w_rh_p) begin
                        r_p2    <= w_p2_inc;
                        r_serve <= 1'b0;
                        r_win   <= (w_p2_inc == r_max);
                        if (w_p2_inc == r_max) begin
                            r_winner <= 1'b1;
                        end
                        r_hold  <= '0;
                        r_state <= StEndPoint;
                    end
                end
                StEndPoint: begin
                    if (i_frame_tick) begin
                        if (r_hold == HOLD_W'(POINT_HOLD_FRAMES - 1)) begin
                            r_hold <= '0;
                            if (r_win) begin
                                r_state <= StEndGame;
                            end else begin
                                r_state      <= StStart;
                                r_serve_load <= 1'b1;
                            end
                        end else begin
                            r_hold <= r_hold + 1'b1;
                        end
                    end
                end
                StEndGame: begin
                    if (w_launch_p) begin
                        r_state  <= StMenu;
                        r_p1     <= 5'd0;
                        r_p2     <= 5'd0;
                        r_max    <= 5'(MAX_SCORE_INIT);
                        r_winner <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StMenu;
                end
            endcase
        end
    end

    assign o_state        = r_state;
    assign o_max_score    = r_max;
    assign o_score_p1     = r_p1;
    assign o_score_p2     = r_p2;
    assign o_serve_player = r_serve;
    assign o_winner       = r_winner;
    assign o_serve_load   = r_serve_load;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed walk through a short game, then random stimulus,
// every cycle compared against a rule-level model of the game flow.
module tb_pong_game_ctrl;

    localparam int HOLD  = 60;
    localparam int INIT  = 5;
    localparam int LIMIT = 20;
    localparam int S_MENU = 0, S_SET = 1, S_START = 2, S_PLAY = 3, S_EP = 4, S_EG = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ft = 1'b0;
    logic       bl = 1'b0;
    logic       bu = 1'b0;
    logic       bd = 1'b0;
    logic       lh = 1'b0;
    logic       rh = 1'b0;
    logic [2:0] o_state;
    logic [4:0] o_max_score;
    logic [4:0] o_score_p1;
    logic [4:0] o_score_p2;
    logic       o_serve_player;
    logic       o_winner;
    logic       o_serve_load;

    int n_total = 0;
    int n_bad   = 0;

    pong_game_ctrl dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_frame_tick   (ft),
        .i_btn_launch   (bl),
        .i_btn_up       (bu),
        .i_btn_down     (bd),
        .i_left_hit     (lh),
        .i_right_hit    (rh),
        .o_state        (o_state),
        .o_max_score    (o_max_score),
        .o_score_p1     (o_score_p1),
        .o_score_p2     (o_score_p2),
        .o_serve_player (o_serve_player),
        .o_winner       (o_winner),
        .o_serve_load   (o_serve_load)
    );

    always #5 clk = ~clk;

    // Model state
    int m_state, m_max, m_p1, m_p2, m_serve, m_winner, m_load, m_win, m_hold, m_edges;
    bit m_hist [3][3];  // per button: samples taken 1, 2 and 3 edges ago
    bit m_lh_prev, m_rh_prev;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_MENU; m_max = INIT; m_p1 = 0; m_p2 = 0; m_serve = 0; m_winner = 0;
        m_load = 0; m_win = 0; m_hold = 0; m_edges = 0;
        m_lh_prev = 0; m_rh_prev = 0;
        for (int b = 0; b < 3; b++) for (int j = 0; j < 3; j++) m_hist[b][j] = 0;
    endtask

    // A button press is seen two edges late, and only if the rising edge lies between two
    // samples taken after reset release.
    task automatic model_step();
        bit pins [3];
        bit pulse [3];
        bit lp, up, dp, lhp, rhp;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_edges++;
        pins[0] = bl; pins[1] = bu; pins[2] = bd;
        for (int b = 0; b < 3; b++) begin
            pulse[b] = (m_edges >= 4) && m_hist[b][1] && !m_hist[b][2];
            m_hist[b][2] = m_hist[b][1];
            m_hist[b][1] = m_hist[b][0];
            m_hist[b][0] = pins[b];
        end
        lp = pulse[0]; up = pulse[1]; dp = pulse[2];
        lhp = lh && !m_lh_prev;
        rhp = rh && !m_rh_prev;
        m_lh_prev = lh;
        m_rh_prev = rh;
        m_load = 0;
        case (m_state)
            S_MENU: if (lp) m_state = S_SET;
            S_SET: begin
                if (lp) begin
                    m_state = S_START; m_p1 = 0; m_p2 = 0; m_serve = 0; m_load = 1;
                end else if (up && !dp) begin
                    m_max = (m_max + 1 > LIMIT) ? LIMIT : m_max + 1;
                end else if (dp && !up) begin
                    m_max = (m_max - 1 < 1) ? 1 : m_max - 1;
                end
            end
            S_START: if (lp) m_state = S_PLAY;
            S_PLAY: begin
                if (rhp != lhp) begin
                    if (rhp) begin
                        m_p1++; m_serve = 1;
                    end else begin
                        m_p2++; m_serve = 0;
                    end
                    m_win = (m_p1 == m_max) || (m_p2 == m_max);
                    if (m_p1 == m_max) m_winner = 0;
                    if (m_p2 == m_max) m_winner = 1;
                    m_hold = 0;
                    m_state = S_EP;
                end
            end
            S_EP: begin
                if (ft) begin
                    m_hold++;
                    if (m_hold == HOLD) begin
                        if (m_win) m_state = S_EG;
                        else begin
                            m_state = S_START; m_load = 1;
                        end
                    end
                end
            end
            S_EG: begin
                if (lp) begin
                    m_state = S_MENU; m_p1 = 0; m_p2 = 0; m_max = INIT; m_winner = 0;
                end
            end
            default: m_state = S_MENU;
        endcase
    endtask

    task automatic compare();
        check("state", int'(o_state), m_state);
        check("max_score", int'(o_max_score), m_max);
        check("score_p1", int'(o_score_p1), m_p1);
        check("score_p2", int'(o_score_p2), m_p2);
        check("serve_player", int'(o_serve_player), m_serve);
        check("winner", int'(o_winner), m_winner);
        check("serve_load", int'(o_serve_load), m_load);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: bl = v;
            1: bu = v;
            default: bd = v;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        repeat (4) cycle();
        set_btn(b, 1'b0);
        repeat (4) cycle();
    endtask

    task automatic run_hold(input int budget);
        int n;
        n = 0;
        while (m_state == S_EP && n < budget) begin
            ft = 1'b1;
            cycle();
            ft = 1'b0;
            cycle();
            n++;
        end
        check("hold_budget", int'(m_state != S_EP), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (3) cycle();
        check("rst_state", int'(o_state), 0);
        check("rst_max", int'(o_max_score), INIT);

        bl = 1'b1;
        repeat (100) cycle();
        check("launch_held_set", int'(o_state), S_SET);
        bl = 1'b0;
        repeat (4) cycle();

        repeat (20) press(1);
        check("up_saturate", int'(o_max_score), LIMIT);
        repeat (25) press(2);
        check("down_saturate", int'(o_max_score), 1);
        bu = 1'b1; bd = 1'b1;
        repeat (4) cycle();
        bu = 1'b0; bd = 1'b0;
        repeat (4) cycle();
        check("up_down_same", int'(o_max_score), 1);
        press(1);
        check("max_two", int'(o_max_score), 2);

        press(0);
        check("to_start", int'(o_state), S_START);
        lh = 1'b1; rh = 1'b1;
        repeat (3) cycle();
        lh = 1'b0; rh = 1'b0;
        repeat (2) cycle();
        check("start_hits_ignored", int'(o_score_p1 + o_score_p2), 0);
        press(0);
        check("to_play", int'(o_state), S_PLAY);

        rh = 1'b1;
        repeat (2) cycle();
        rh = 1'b0;
        repeat (2) cycle();
        check("p1_point", int'(o_score_p1), 1);
        check("p1_serve", int'(o_serve_player), 1);
        run_hold(400);
        check("back_to_start", int'(o_state), S_START);

        press(0);
        lh = 1'b1; rh = 1'b1;
        repeat (2) cycle();
        lh = 1'b0; rh = 1'b0;
        cycle();
        check("both_hits_play", int'(o_state), S_PLAY);
        check("both_hits_p2", int'(o_score_p2), 0);
        rh = 1'b1;
        repeat (2) cycle();
        rh = 1'b0;
        repeat (2) cycle();
        check("p1_two", int'(o_score_p1), 2);
        run_hold(400);
        check("end_game", int'(o_state), S_EG);
        check("winner_p1", int'(o_winner), 0);
        press(0);
        check("menu_again", int'(o_state), S_MENU);
        check("menu_max", int'(o_max_score), INIT);

        press(0);
        press(0);
        press(0);
        lh = 1'b1;
        repeat (2) cycle();
        lh = 1'b0;
        cycle();
        check("p2_point", int'(o_score_p2), 1);
        repeat (30) begin
            ft = 1'b1;
            cycle();
            ft = 1'b0;
            cycle();
        end
        bl = 1'b1;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare();
        check("rst_mid_state", int'(o_state), S_MENU);
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (10) cycle();
        check("held_after_rst", int'(o_state), S_MENU);
        bl = 1'b0;
        repeat (4) cycle();

        for (int i = 0; i < 12000; i++) begin
            if ($urandom_range(0, 7) == 0) bl = ~bl;
            if ($urandom_range(0, 5) == 0) bu = ~bu;
            if ($urandom_range(0, 6) == 0) bd = ~bd;
            if ($urandom_range(0, 11) == 0) lh = ~lh;
            if ($urandom_range(0, 11) == 0) rh = ~rh;
            ft = 1'($urandom_range(0, 1));
            if (rst_n && $urandom_range(0, 2999) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                compare();
            end else if (!rst_n) begin
                rst_n = 1'b1;
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Synchronous game-sequencing stage directly upstream of the draw/animation top: owns the game state, max-score setting, both scores, serve side and winner. It consumes raw pushbuttons plus the ball logic's wall-hit pulses, and drives state/score/serve to the drawing and 7-seg display logic. It replaces the ad-hoc multi-clock state control with one clock domain.

Parameters:
MAX_SCORE_INIT, 5, max_score value after reset and on return to MENU
MAX_SCORE_LIMIT, 20, upper bound for max_score (lower bound fixed at 1)
POINT_HOLD_FRAMES, 60, frame_tick count spent in END_POINT before advancing

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
frame_tick  input  1  one-cycle pulse per frame (animate strobe)
btn_launch  input  1  raw centre button, asynchronous
btn_up  input  1  raw up button, asynchronous
btn_down  input  1  raw down button, asynchronous
left_hit  input  1  ball reached left wall (level or pulse; edge taken internally)
right_hit  input  1  ball reached right wall (level or pulse)
state  output  3  MENU=0 SET=1 START=2 PLAY=3 END_POINT=4 END_GAME=5
max_score  output  5  points needed to win
score_p1  output  5  left player score
score_p2  output  5  right player score
serve_player  output  1  0 = ball starts at left paddle, 1 = right
winner  output  1  0 = p1, 1 = p2; valid in END_GAME
serve_load  output  1  one-cycle pulse on every entry to START

Behaviour:
- Reset (reset=0, async): state=MENU, max_score=MAX_SCORE_INIT, scores=0, serve_player=0, winner=0, serve_load=0, hold counter=0, sync/edge flops=0.
- Buttons: 2-flop synchroniser each, then rising-edge detect -> one-cycle pulses launch_p, up_p, down_p. Latency from pin to pulse: 3 clk. Held button yields exactly one pulse.
- Hits: rising-edge detect on left_hit/right_hit (1 flop) -> lh_p, rh_p; sampled only in PLAY, ignored elsewhere.
- All transitions on clk edge; one transition per cycle max.
- MENU: launch_p -> SET.
- SET: up_p -> max_score+1, saturate at MAX_SCORE_LIMIT; down_p -> max_score-1, saturate at 1; up_p and down_p same cycle -> no change. launch_p -> START, clear scores, serve_player=0. Launch wins over up/down same cycle (max_score unchanged).
- START: serve_load=1 on the entry cycle only. launch_p -> PLAY.
- PLAY: rh_p alone -> score_p1+1, serve_player=1, -> END_POINT. lh_p alone -> score_p2+1, serve_player=0, -> END_POINT. rh_p and lh_p same cycle -> no score, stay PLAY. launch/up/down ignored.
- Win check on END_POINT entry: score_p1==max_score -> winner=0; score_p2==max_score -> winner=1; flag registered with the score update.
- END_POINT: hold counter cleared on entry, +1 per frame_tick; when count reaches POINT_HOLD_FRAMES -> END_GAME if win flag, else START. Buttons ignored.
- END_GAME: scores and winner held for display; launch_p -> MENU, scores=0, max_score=MAX_SCORE_INIT, winner=0.
- Scores 5-bit, never exceed max_score (game ends at equality). Unused encodings 6,7 -> MENU next cycle.
- Reset asserted mid-game returns to reset values immediately; first launch after release must be a fresh rising edge (a held button produces no pulse).

Test Plan:
- Reset release, pulse btn_launch 4 clk -> state 0->1 after 3-4 clk; holding btn_launch 100 clk still yields only SET.
- In SET, 20 up pulses from 5 -> max_score=20 (saturates); 25 down pulses -> 1; up+down same cycle -> unchanged.
- max_score=2: START, launch, right_hit -> score_p1=1, serve_player=1, END_POINT; after 60 frame_ticks -> START with serve_load pulse of exactly 1 clk.
- Second right_hit -> score_p1=2, after hold -> END_GAME, winner=0; launch -> MENU, scores 0, max_score=5.
- In PLAY, left_hit and right_hit rise same cycle -> scores unchanged, state stays PLAY; hits asserted in START -> ignored.
- Assert reset in END_POINT at hold count 30 -> all outputs at reset values within the same cycle; launch held through release -> stays MENU.
